// File: rtl/cyclic_shift_reg_ctrl.sv
// rtl/cyclic_shift_reg_ctrl.sv - load/rotate sequencer for one cyclic shift register
//
// Purpose:
//   The controller takes one config, then loads (cfg_w_addr_max+1) wide beats into the
//   shift register. After that it rotates the register out as
//   (cfg_r_addr_max+1)*(cfg_repeats+1) narrow words under consumer backpressure.
//   The data path does not pass through this block. s_data goes straight to the
//   shift register, and m_data is the register's head word.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   clken               global clock enable; low freezes every register
//   cfg_*               config handshake (accepted only in IDLE)
//   s_valid / s_ready   write-beat handshake (ready only in LOAD)
//   w_en, w_addr        write strobe and beat index to the shift register
//   r_en                rotate-by-one strobe to the shift register
//   r_addr_max          latched last read index of a pass
//   w_addr_max          latched last write beat index
//   m_valid / m_ready   read-word handshake (valid only in READ)
//   m_pass_last         current word closes a pass
//   m_last              current word closes the final pass
//   busy                controller is not idle

module cyclic_shift_reg_ctrl #(
  parameter int R_DEPTH      = 24,
  parameter int R_DATA_WIDTH = 16,
  parameter int W_DATA_WIDTH = 192,
  parameter int REPEAT_WIDTH = 8,
  localparam int W_DEPTH      = R_DEPTH * R_DATA_WIDTH / W_DATA_WIDTH,
  localparam int R_ADDR_WIDTH = (R_DEPTH > 1) ? $clog2(R_DEPTH) : 1,
  localparam int W_ADDR_WIDTH = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [R_ADDR_WIDTH-1:0] cfg_r_addr_max,
  input  logic [W_ADDR_WIDTH-1:0] cfg_w_addr_max,
  input  logic [REPEAT_WIDTH-1:0] cfg_repeats,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    w_en,
  output logic [W_ADDR_WIDTH-1:0] w_addr,
  output logic                    r_en,
  output logic [R_ADDR_WIDTH-1:0] r_addr_max,
  output logic [W_ADDR_WIDTH-1:0] w_addr_max,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_pass_last,
  output logic                    m_last,
  output logic                    busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_READ = 2'd2;

  logic [1:0]              r_state;
  logic [W_ADDR_WIDTH-1:0] r_w_addr;
  logic [R_ADDR_WIDTH-1:0] r_word;
  logic [REPEAT_WIDTH-1:0] r_pass;
  logic [R_ADDR_WIDTH-1:0] r_r_addr_max;
  logic [W_ADDR_WIDTH-1:0] r_w_addr_max;
  logic [REPEAT_WIDTH-1:0] r_repeats;

  logic w_is_idle;
  logic w_is_load;
  logic w_is_read;
  logic w_word_end;
  logic w_pass_end;

  assign w_is_idle  = (r_state == S_IDLE);
  assign w_is_load  = (r_state == S_LOAD);
  assign w_is_read  = (r_state == S_READ);
  assign w_word_end = (r_word == r_r_addr_max);
  assign w_pass_end = (r_pass == r_repeats);

  // All handshake outputs decode straight from state so they add no latency.
  assign cfg_ready   = w_is_idle;
  assign s_ready     = w_is_load;
  assign m_valid     = w_is_read;
  assign busy        = !w_is_idle;
  assign w_en        = s_valid & w_is_load & clken;
  assign r_en        = m_ready & w_is_read & clken;
  assign w_addr      = r_w_addr;
  assign r_addr_max  = r_r_addr_max;
  assign w_addr_max  = r_w_addr_max;
  assign m_pass_last = w_is_read & w_word_end;
  assign m_last      = w_is_read & w_word_end & w_pass_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_w_addr     <= '0;
      r_word       <= '0;
      r_pass       <= '0;
      r_r_addr_max <= '0;
      r_w_addr_max <= '0;
      r_repeats    <= '0;
    end else if (clken) begin
      case (r_state)
        S_IDLE: begin
          if (cfg_valid) begin
            r_r_addr_max <= cfg_r_addr_max;
            r_w_addr_max <= cfg_w_addr_max;
            r_repeats    <= cfg_repeats;
            r_w_addr     <= '0;
            r_word       <= '0;
            r_pass       <= '0;
            r_state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (s_valid) begin
            if (r_w_addr == r_w_addr_max) begin
              r_w_addr <= '0;
              r_state  <= S_READ;
            end else begin
              r_w_addr <= r_w_addr + 1'b1;
            end
          end
        end
        S_READ: begin
          if (m_ready) begin
            if (w_word_end) begin
              // The counters compare for equality, so the pass counter never
              // needs to exceed r_repeats before the next config clears it.
              r_word <= '0;
              r_pass <= r_pass + 1'b1;
              if (w_pass_end) begin
                r_state <= S_IDLE;
              end
            end else begin
              r_word <= r_word + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
